replay_scheduler: RTL and testbench
===================================

Name: replay_scheduler

Overview:
- Round-robin scheduler that shares one downstream replay port among N requester blocks.
- Each requester raises a replay request. The scheduler grants one requester at a time, holds that grant until downstream accepts it, and then enforces a cooldown gap before the next grant.
- Sits above a bank of replay-producing blocks. It replaces their flat AND/OR reduction with an ordered, one-at-a-time replay stream and a saturating replay counter.

Parameters:
- N, 3, number of requesters (2..8)
- IDX_W, 2, width of the grant index; must satisfy 2^IDX_W >= N
- COOLDOWN, 2, idle cycles forced after each accepted replay (0..15)
- CNT_W, 8, width of the saturating replay counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- io_req_valid  in  N  per-requester replay request; a requester holds it until its ready bit is seen
- io_req_ready  out  N  per-requester acknowledge, one-hot, combinational
- io_out_valid  out  1  a replay is presented downstream
- io_out_ready  in  1  downstream accepts the presented replay
- io_out_idx  out  IDX_W  index of the granted requester; valid while io_out_valid=1
- io_busy  out  1  high whenever state is not IDLE
- io_replay_count  out  CNT_W  number of accepted replays, saturating
- io_clear  in  1  synchronous clear of io_replay_count

Behaviour:
Reset (asynchronous, on reset=1):
- state=IDLE, ptr=0, grant=0, cooldown counter=0, count=0.
- io_out_valid=0, io_out_idx=0, io_req_ready=0, io_busy=0, io_replay_count=0.

Arbitration (round-robin):
- Priority order is ptr, ptr+1, ..., wrapping modulo N (ptr=N-1 wraps to 0).
- The winner is the first index in that order with io_req_valid set.

IDLE state:
- If any io_req_valid bit is set: grant <= winner, then go to GRANT.
- Latency is exactly 1 cycle: request seen at edge k gives io_out_valid=1 in cycle k+1.

GRANT state:
- io_out_valid=1 and io_out_idx=grant; both stay stable until the handshake completes.
- Handshake cycle (io_out_valid & io_out_ready):
  - io_req_ready[grant]=1 in that same cycle; all other ready bits are 0.
  - ptr <= (grant+1) mod N.
  - count <= count+1, saturating at 2^CNT_W-1.
  - Next state is COOLDOWN with counter=COOLDOWN-1, or IDLE if COOLDOWN=0.
- Abort: if io_req_valid[grant]=0 in a GRANT cycle without a handshake, go to IDLE. There is no count increment, no ptr change and no ready pulse.
- New requests arriving during GRANT do not change grant.

COOLDOWN state:
- io_out_valid=0.
- The counter decrements each cycle; when it reaches 0, go to IDLE.
- This gives exactly COOLDOWN cycles between the handshake cycle and the IDLE cycle.
- Requests are ignored (not sampled) during COOLDOWN.

io_clear:
- count <= 0 on the next edge.
- If a clear coincides with a handshake, the clear wins and count becomes 0.

Other rules:
- io_busy is derived combinationally from state (state != IDLE).
- io_req_ready is never asserted outside a handshake cycle.
- Reset asserted in any state returns every output to its reset value immediately. The in-flight replay is dropped and counted as not accepted.

Decomposition:
- Shared package holds the state encoding (IDLE=0, GRANT=1, COOLDOWN=2, 2 bits) and a helper for the IDX_W check.
- One sub-module, rr_pick: combinational round-robin priority pick.
  - Inputs: req[N], ptr[IDX_W].
  - Outputs: any, idx[IDX_W].
- The scheduler FSM, counters and handshake logic stay in replay_scheduler.

Test Plan:
- Single request, 1-cycle accept:
  - Stimulus: reset released; io_req_valid=3'b010 at edge 0; io_out_ready=1.
  - Response: cycle 1 shows io_out_valid=1, io_out_idx=1, io_req_ready=3'b010, io_replay_count=1 after the edge; io_busy stays high for 2 cooldown cycles, then IDLE.
- All requesters active, ready always 1, COOLDOWN=2:
  - Grant order is 0,1,2,0.
  - Successive io_out_valid pulses are exactly 3 cycles apart.
  - After 4 grants, io_replay_count=4.
- Backpressure:
  - Stimulus: req=3'b100, io_out_ready=0 for 5 cycles, then 1.
  - Response: io_out_valid=1 with io_out_idx=2 held stable all 5 cycles; a single ready pulse on bit 2 only in the accept cycle.
- Abort:
  - Stimulus: grant to index 0, then io_req_valid[0] drops before io_out_ready.
  - Response: next cycle is IDLE; count is unchanged; ptr stays 0, so a re-request on bits 0 and 1 grants 0.
- Saturation and clear:
  - Stimulus: with CNT_W=2, run 5 accepted replays.
  - Response: count holds 3; io_clear asserted in the same cycle as a handshake gives count=0.
- Asynchronous reset in GRANT:
  - Stimulus: assert reset mid-cycle while in GRANT.
  - Response: io_out_valid and io_busy go to 0 without waiting for a clock edge; after release, the first grant uses ptr=0.

Source files
------------

// File: rtl/replay_scheduler_pkg.sv
// Shared types and helpers for the replay scheduler.
package replay_scheduler_pkg;

    // Cooldown counter width; covers COOLDOWN values 0..15.
    localparam int unsigned CD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    // True when an index of width w can address all n requesters.
    function automatic bit idx_w_ok(input int unsigned n, input int unsigned w);
        return (w < 32) && ((32'd1 << w) >= n);
    endfunction

endpackage

// File: rtl/replay_scheduler_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    localparam int unsigned CW = IDX_W + 1;

    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        logic [CW-1:0] cand;
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int off = int'(N) - 1; off >= 0; off--) begin
            cand = {1'b0, ptr} + CW'(off);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (req[cand[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/replay_scheduler.sv
// Shares one downstream replay port among N requesters: round-robin grant,
// hold until accepted, then a fixed cooldown gap; counts accepted replays.
module replay_scheduler
    import replay_scheduler_pkg::*;
#(
    parameter int unsigned N        = 3,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned COOLDOWN = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     io_req_valid,
    output logic [N-1:0]     io_req_ready,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [IDX_W-1:0] io_out_idx,
    output logic             io_busy,
    output logic [CNT_W-1:0] io_replay_count,
    input  logic             io_clear
);

    if (!idx_w_ok(N, IDX_W)) begin : g_idx_w_check
        $error("replay_scheduler: IDX_W too narrow for N");
    end

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant;
    logic [CD_W-1:0]    cd_cnt;
    logic [CNT_W-1:0]   count;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               handshake;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (io_req_valid),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign handshake       = (state == ST_GRANT) && io_out_ready;
    assign io_out_valid    = (state == ST_GRANT);
    assign io_out_idx      = grant;
    assign io_busy         = (state != ST_IDLE);
    assign io_replay_count = count;

    // One-hot acknowledge to the granted requester, only in the handshake cycle.
    always_comb begin
        io_req_ready = '0;
        if (handshake) begin
            io_req_ready[grant] = 1'b1;
        end
    end

    // Scheduler FSM, round-robin pointer, cooldown timer and saturating count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            grant  <= '0;
            cd_cnt <= '0;
            count  <= '0;
        end else begin
            if (io_clear) begin
                count <= '0;
            end else if (handshake && (count != '1)) begin
                count <= count + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant <= pick_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (handshake) begin
                        ptr <= (grant == IDX_W'(N - 1)) ? '0 : grant + IDX_W'(1);
                        if (COOLDOWN == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            cd_cnt <= CD_W'(COOLDOWN - 1);
                            state  <= ST_COOLDOWN;
                        end
                    end else if (!io_req_valid[grant]) begin
                        state <= ST_IDLE;
                    end
                end
                ST_COOLDOWN: begin
                    if (cd_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cd_cnt <= cd_cnt - CD_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_replay_scheduler.sv
// Bench for replay_scheduler: directed scenarios with literal expectations plus
// a cycle-level model of the scheduling rules compared on every negative edge.
`timescale 1ns/1ps
module tb_replay_scheduler;

    localparam int N  = 3;
    localparam int CD = 2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [2:0] req   = 3'b000;
    logic       oready = 1'b0;
    logic       clear = 1'b0;

    logic [2:0] rdy;
    logic       ovalid;
    logic [1:0] oidx;
    logic       busy;
    logic [7:0] cnt;

    logic [2:0] rdy2;
    logic       ovalid2;
    logic [1:0] oidx2;
    logic       busy2;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    replay_scheduler #(.N(3), .IDX_W(2), .COOLDOWN(2), .CNT_W(8)) dut (
        .clk             (clk),
        .reset           (rst),
        .io_req_valid    (req),
        .io_req_ready    (rdy),
        .io_out_valid    (ovalid),
        .io_out_ready    (oready),
        .io_out_idx      (oidx),
        .io_busy         (busy),
        .io_replay_count (cnt),
        .io_clear        (clear)
    );

    replay_scheduler #(.N(3), .IDX_W(2), .COOLDOWN(2), .CNT_W(2)) dut_sat (
        .clk             (clk),
        .reset           (rst),
        .io_req_valid    (req),
        .io_req_ready    (rdy2),
        .io_out_valid    (ovalid2),
        .io_out_ready    (oready),
        .io_out_idx      (oidx2),
        .io_busy         (busy2),
        .io_replay_count (cnt2),
        .io_clear        (clear)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a replay is either pending (presented downstream) or the port is
    // quiet for a number of cycles after an accept; otherwise requests are picked.
    bit m_pending = 1'b0;
    bit m_hs      = 1'b0;
    int m_idx     = 0;
    int m_ptr     = 0;
    int m_quiet   = 0;
    int m_cnt8    = 0;
    int m_cnt2    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending = 1'b0;
            m_idx     = 0;
            m_ptr     = 0;
            m_quiet   = 0;
            m_cnt8    = 0;
            m_cnt2    = 0;
        end else begin
            m_hs = m_pending && oready;
            if (clear) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end else if (m_hs) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
            if (m_pending) begin
                if (m_hs) begin
                    m_ptr     = (m_idx + 1) % N;
                    m_pending = 1'b0;
                    m_quiet   = CD;
                end else if (!req[m_idx]) begin
                    m_pending = 1'b0;
                end
            end else if (m_quiet > 0) begin
                m_quiet--;
            end else if (req != 3'b000) begin
                for (int off = N - 1; off >= 0; off--) begin
                    if (req[(m_ptr + off) % N]) m_idx = (m_ptr + off) % N;
                end
                m_pending = 1'b1;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        int exp_rdy;
        exp_rdy = (m_pending && oready) ? (1 << m_idx) : 0;
        chk("m_valid", ovalid, m_pending);
        chk("m_busy", busy, (m_pending || m_quiet > 0) ? 1 : 0);
        chk("m_ready", rdy, exp_rdy);
        chk("m_count", cnt, m_cnt8);
        chk("m_valid_sat", ovalid2, m_pending);
        chk("m_busy_sat", busy2, (m_pending || m_quiet > 0) ? 1 : 0);
        chk("m_ready_sat", rdy2, exp_rdy);
        chk("m_count_sat", cnt2, m_cnt2);
        if (m_pending) begin
            chk("m_idx", oidx, m_idx);
            chk("m_idx_sat", oidx2, m_idx);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req    = 3'b000;
        oready = 1'b0;
        clear  = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        req    = 3'b000;
        oready = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int gap;
        int acc;
        int order [4];
        bit seen;

        // Reset values
        tick();
        tick();
        chk("rst_valid", ovalid, 0);
        chk("rst_idx", oidx, 0);
        chk("rst_ready", rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", cnt, 0);
        rst = 1'b0;

        // Single request, 1-cycle accept
        req = 3'b010; oready = 1'b1;
        tick(); #1;
        chk("single_valid", ovalid, 1);
        chk("single_idx", oidx, 1);
        chk("single_ready", rdy, 3'b010);
        tick(); req = 3'b000; #1;
        chk("single_count", cnt, 1);
        chk("single_cd1_busy", busy, 1);
        chk("single_cd1_valid", ovalid, 0);
        tick(); #1;
        chk("single_cd2_busy", busy, 1);
        tick(); #1;
        chk("single_idle_busy", busy, 0);

        // All requesters active, ready always high
        do_reset();
        req = 3'b111; oready = 1'b1;
        grants = 0; gap = 0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            tick(); #1;
            if (ovalid) begin
                order[grants] = int'(oidx);
                if (grants > 0) chk("rr_gap", gap, 3);
                gap = 0;
                grants++;
                if (grants == 4) req = 3'b000;
            end else begin
                gap++;
            end
        end
        chk("rr_grants", grants, 4);
        chk("rr_order0", order[0], 0);
        chk("rr_order1", order[1], 1);
        chk("rr_order2", order[2], 2);
        chk("rr_order3", order[3], 0);
        tick(); #1;
        chk("rr_count", cnt, 4);
        chk("rr_count_sat", cnt2, 3);
        drain(3);

        // Backpressure
        do_reset();
        req = 3'b100; oready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", ovalid, 1);
            chk("bp_idx", oidx, 2);
            chk("bp_ready_low", rdy, 0);
            tick();
        end
        oready = 1'b1; #1;
        chk("bp_accept_ready", rdy, 3'b100);
        chk("bp_accept_idx", oidx, 2);
        tick(); req = 3'b000; oready = 1'b0; #1;
        chk("bp_after_ready", rdy, 0);
        chk("bp_after_valid", ovalid, 0);
        chk("bp_count", cnt, 1);
        drain(3);

        // Abort: request withdrawn before accept
        do_reset();
        req = 3'b001; oready = 1'b0;
        tick(); #1;
        chk("abort_valid", ovalid, 1);
        chk("abort_idx", oidx, 0);
        req = 3'b000;
        tick(); #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid_after", ovalid, 0);
        chk("abort_count", cnt, 0);
        req = 3'b011;
        tick(); #1;
        chk("abort_regrant_valid", ovalid, 1);
        chk("abort_regrant_idx", oidx, 0);
        oready = 1'b1;
        tick();
        drain(3);

        // Saturation and clear
        do_reset();
        req = 3'b001; oready = 1'b1;
        acc = 0;
        for (int c = 0; c < 60 && acc < 5; c++) begin
            tick(); #1;
            if (ovalid) acc++;
        end
        chk("sat_accepts", acc, 5);
        tick(); #1;
        chk("sat_count", cnt2, 3);
        chk("sat_count_wide", cnt, 5);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick(); #1;
            if (ovalid) seen = 1'b1;
        end
        chk("clear_grant_seen", seen, 1);
        clear = 1'b1;
        tick(); clear = 1'b0; #1;
        chk("clear_count_sat", cnt2, 0);
        chk("clear_count_wide", cnt, 0);
        drain(4);

        // Asynchronous reset while in GRANT
        req = 3'b010; oready = 1'b0;
        tick(); #1;
        chk("areset_pre_valid", ovalid, 1);
        chk("areset_pre_idx", oidx, 1);
        #1 rst = 1'b1;
        #1;
        chk("areset_valid", ovalid, 0);
        chk("areset_busy", busy, 0);
        chk("areset_count", cnt, 0);
        tick();
        rst = 1'b0;
        req = 3'b011;
        tick(); #1;
        chk("areset_regrant_valid", ovalid, 1);
        chk("areset_regrant_idx", oidx, 0);
        oready = 1'b1;
        tick();
        drain(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
